wb_initiator: RTL and testbench

- Wishbone classic single-transfer bus initiator (master). It is the initiator-side counterpart to the team's user-area Wishbone slaves.
- Accepts one command at a time on a valid/ready request port and runs exactly one Wishbone cycle. It then returns read data and a completion status on a valid/ready response port.
- Used by LA/test logic and on-chip sequencers to drive user-area slaves, e.g. the 0x3000_0000 adder register, without the management SoC.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_timeout_ctr.sv | 41 ++++
 rtl/wb_initiator.sv | 164 ++++++++++++++++
 tb/tb_wb_initiator.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone initiator types: bus widths, completion status codes, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [1:0] WB_ST_OK      = 2'b00;
    localparam logic [1:0] WB_ST_ERR     = 2'b01;
    localparam logic [1:0] WB_ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter with clear/enable and a terminal-count flag at TIMEOUT_CYCLES-1.
// Latency: tc reflects the registered count (no combinational path from en).
// Backpressure: none; a limit of 0 keeps tc permanently low.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(LAST));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// Latency: bus active the cycle after accept; response valid the cycle after ack/err/timeout.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready, no overlap with next accept.
module wb_initiator
    import wb_pkg::*;
#(
    parameter logic [WB_ADR_W-1:0] BASE_MASK      = 32'hFFFF_FFFF,
    parameter int unsigned         TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic [1:0]          rsp_status,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    output logic                busy
);

    wb_state_e           state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]          rsp_status_q, rsp_status_d;

    logic in_bus;
    logic to_tc;
    logic term_err;
    logic term_ack;
    logic term_to;
    logic term;

    // Termination priority inside BUS: error, then ack, then timeout.
    assign in_bus   = (state_q == ST_BUS);
    assign term_err = in_bus && wbm_err_i;
    assign term_ack = in_bus && !wbm_err_i && wbm_ack_i;
    assign term_to  = in_bus && !wbm_err_i && !wbm_ack_i && to_tc;
    assign term     = term_err || term_ack || term_to;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk  (clk),
        .reset(reset),
        .clr  (term || !in_bus),
        .en   (in_bus),
        .tc   (to_tc)
    );

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= WB_ST_OK;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    // Next-state: accept, terminate, hand off response.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_BUS;
            ST_BUS:  if (term)      state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: load command on accept, capture response on termination.
    always_comb begin
        cyc_d        = cyc_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rsp_vld_d    = rsp_vld_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cyc_d = 1'b1;
                    we_d  = cmd_we;
                    sel_d = cmd_sel;
                    adr_d = cmd_adr & BASE_MASK;
                    dat_d = cmd_dat;
                end
            end
            ST_BUS: begin
                if (term) begin
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = '0;
                    dat_d     = '0;
                    rsp_vld_d = 1'b1;
                    if (term_err) begin
                        rsp_status_d = WB_ST_ERR;
                    end else if (term_ack) begin
                        rsp_status_d = WB_ST_OK;
                    end else begin
                        rsp_status_d = WB_ST_TIMEOUT;
                    end
                    // Only a successful read carries data back.
                    rsp_dat_d = (term_ack && !we_q) ? wbm_dat_i : '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) rsp_vld_d = 1'b0;
            end
            default: begin
                cyc_d     = 1'b0;
                rsp_vld_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = rsp_vld_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Testbench for wb_initiator: behavioural slave with configurable response plus a transaction-level model.
// Latency: n/a.
// Backpressure: exercised via rsp_ready hold-off.
module tb_wb_initiator;

    localparam logic [31:0] MASK      = 32'h3FFF_FFFF;
    localparam int          TO        = 16;
    localparam logic [31:0] ADDER_ADR = 32'h3000_0000;
    localparam logic [1:0]  S_OK      = 2'b00;
    localparam logic [1:0]  S_ERR     = 2'b01;
    localparam logic [1:0]  S_TO      = 2'b10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] wbm_dat_i;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Slave model: mode 0 ack, 1 silent, 2 ack+err together, 3 err only; responds in stb cycle slv_delay.
    int          slv_mode = 0;
    int          slv_delay = 1;
    logic [31:0] slv_rdata = '0;
    logic        stray_ack = 1'b0;
    int          bus_cnt = 0;
    logic [31:0] adder_q = '0;
    logic        slv_hit;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o) bus_cnt <= bus_cnt + 1;
        else                        bus_cnt <= 0;
        if (wbm_ack_i && !wbm_err_i && wbm_we_o && wbm_adr_o == ADDER_ADR) adder_q <= wbm_dat_o;
    end

    assign slv_hit   = wbm_cyc_o && wbm_stb_o && (bus_cnt == slv_delay - 1);
    assign wbm_ack_i = stray_ack || (slv_hit && (slv_mode == 0 || slv_mode == 2));
    assign wbm_err_i = slv_hit && (slv_mode == 2 || slv_mode == 3);
    assign wbm_dat_i = (wbm_adr_o == ADDER_ADR) ? (32'(adder_q[7:4]) + 32'(adder_q[3:0])) : slv_rdata;

    wb_initiator #(
        .BASE_MASK     (MASK),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wbm_dat_i (wbm_dat_i),
        .busy      (busy)
    );

    // Drives one transaction from a negedge and reports what the bus and response looked like.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int mode, input int dly, input logic [31:0] rd,
                           output logic [1:0] st, output logic [31:0] rdat, output int ncyc,
                           output logic held_ok, output logic end_ok, output logic hung);
        int n;
        hung = 1'b0; held_ok = 1'b1; ncyc = 0;
        slv_mode = mode; slv_delay = dly; slv_rdata = rd;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) hung = 1'b1;
        @(negedge clk);
        // Scramble inputs after accept; the bus must keep the accepted values.
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
        while (wbm_cyc_o && ncyc < 200) begin
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== (adr & MASK) ||
                wbm_dat_o !== dat || wbm_sel_o !== sel || rsp_valid !== 1'b0) held_ok = 1'b0;
            ncyc++;
            @(negedge clk);
        end
        if (wbm_cyc_o) hung = 1'b1;
        end_ok = (wbm_stb_o === 1'b0 && wbm_we_o === 1'b0 && wbm_sel_o === 4'h0 &&
                  wbm_dat_o === 32'h0 && rsp_valid === 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!rsp_valid) hung = 1'b1;
        st = rsp_status; rdat = rsp_dat;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat, rsp_status, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rv=%b rd=%h rs=%b busy=%b, all required 0",
                     wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat, rsp_status, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_read();
        logic [1:0] st; logic [31:0] rd; int nc; logic held, eok, hung;
        run_txn(1'b1, ADDER_ADR, 32'h0000_0053, 4'hF, 0, 1, 32'h0, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || !held || !eok || nc != 1 || st !== S_OK || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_adder: hung=%b held=%b end=%b cycles=%0d st=%b dat=%h, required 0/1/1/1/00/0", hung, held, eok, nc, st, rd);
        end
        run_txn(1'b0, ADDER_ADR, 32'h0, 4'hF, 0, 1, 32'h0, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || !held || st !== S_OK || rd !== 32'h0000_0008) begin
            tests_failed++;
            $display("FAIL read_adder: hung=%b held=%b st=%b dat=%h, required st 00 dat 00000008", hung, held, st, rd);
        end
    endtask

    task automatic test_min_latency();
        slv_mode = 0; slv_delay = 1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = ADDER_ADR; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_bus: cyc=%b rv=%b rdy=%b, required 1/0/0", wbm_cyc_o, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        tests_run++;
        if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h8) begin
            tests_failed++;
            $display("FAIL latency_rsp: cyc=%b rv=%b dat=%h, required 0/1/00000008", wbm_cyc_o, rsp_valid, rsp_dat);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_ready: rv=%b rdy=%b, required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_delayed_read();
        logic [1:0] st; logic [31:0] rd; int nc; logic held, eok, hung;
        run_txn(1'b0, 32'h0000_1004, 32'h1234_5678, 4'h3, 0, 10, 32'hDEAD_BEEF, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || !held || !eok || nc != 10 || st !== S_OK || rd !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL delayed_read: hung=%b held=%b end=%b cycles=%0d st=%b dat=%h, required cycles 10 st 00 dat deadbeef",
                     hung, held, eok, nc, st, rd);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] st; logic [31:0] rd; int nc; logic held, eok, hung;
        run_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 1, 1, 32'hFFFF_FFFF, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || !held || !eok || nc != TO || st !== S_TO || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL timeout: hung=%b held=%b end=%b cycles=%0d st=%b dat=%h, required cycles %0d st 10 dat 0",
                     hung, held, eok, nc, st, rd, TO);
        end
    endtask

    task automatic test_timeout_boundary();
        logic [1:0] st; logic [31:0] rd; int nc; logic held, eok, hung;
        run_txn(1'b0, 32'h0000_2004, 32'h0, 4'hF, 0, TO, 32'hA5A5_0001, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || nc != TO || st !== S_OK || rd !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL ack_on_last_cycle: hung=%b cycles=%0d st=%b dat=%h, required cycles %0d st 00 dat a5a50001", hung, nc, st, rd, TO);
        end
        run_txn(1'b0, 32'h0000_2008, 32'h0, 4'hF, 0, TO + 1, 32'hA5A5_0002, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || nc != TO || st !== S_TO || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL ack_after_timeout: hung=%b cycles=%0d st=%b dat=%h, required cycles %0d st 10 dat 0", hung, nc, st, rd, TO);
        end
    endtask

    task automatic test_ack_err();
        logic [1:0] st; logic [31:0] rd; int nc; logic held, eok, hung;
        run_txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 2, 3, 32'h7777_7777, st, rd, nc, held, eok, hung);
        tests_run++;
        if (hung || !eok || nc != 3 || st !== S_ERR || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL ack_err_same_cycle: hung=%b end=%b cycles=%0d st=%b dat=%h, required cycles 3 st 01 dat 0", hung, eok, nc, st, rd);
        end
    endtask

    task automatic test_backpressure();
        int n;
        slv_mode = 0; slv_delay = 2; slv_rdata = 32'hC0FF_EE01;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_4000; cmd_dat = 32'h0; cmd_sel = 4'hF;
        @(negedge clk);
        // Second command presented immediately and held.
        cmd_we = 1'b1; cmd_adr = 32'hF000_4400; cmd_dat = 32'h1111_2222; cmd_sel = 4'h5;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hC0FF_EE01 || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: rv=%b dat=%h rdy=%b cyc=%b, required 1/c0ffee01/0/0",
                         i, rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL handoff_no_accept: rv=%b rdy=%b cyc=%b, required 0/1/0", rsp_valid, cmd_ready, wbm_cyc_o);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_adr_o !== (32'hF000_4400 & MASK) || wbm_sel_o !== 4'h5) begin
            tests_failed++;
            $display("FAIL second_accept: cyc=%b we=%b adr=%h sel=%h, required 1/1/%h/5", wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
                     32'hF000_4400 & MASK);
        end
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_status !== S_OK || rsp_dat !== 32'h0) begin
            tests_failed++;
            $display("FAIL second_rsp: rv=%b st=%b dat=%h, required 1/00/0", rsp_valid, rsp_status, rsp_dat);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        slv_mode = 1; slv_delay = 1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_5000; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_bus: cyc=%b stb=%b, required 1/1", wbm_cyc_o, wbm_stb_o);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_bus: cyc=%b stb=%b rv=%b busy=%b rdy=%b, required 0/0/0/0/1",
                     wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready);
        end
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL stray_ack[%0d]: rv=%b busy=%b cyc=%b, required 0/0/0", i, rsp_valid, busy, wbm_cyc_o);
            end
        end
        stray_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] st, exp_st; logic [31:0] rd, exp_dat; int nc, exp_n; logic held, eok, hung;
        logic we; logic [31:0] adr, dat, rdata; logic [3:0] sel; int mode, dly, r;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            adr = $urandom | 32'h1;
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            rdata = $urandom;
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 3 : (r == 8) ? 2 : 1;
            dly = $urandom_range(1, 20);
            // Reference: a silent slave or one slower than the limit times out after TO cycles.
            if (mode == 1 || dly > TO) begin
                exp_st = S_TO; exp_n = TO;
            end else if (mode == 0) begin
                exp_st = S_OK; exp_n = dly;
            end else begin
                exp_st = S_ERR; exp_n = dly;
            end
            exp_dat = (exp_st == S_OK && !we) ? rdata : 32'h0;
            run_txn(we, adr, dat, sel, mode, dly, rdata, st, rd, nc, held, eok, hung);
            tests_run++;
            if (hung || !held || !eok || nc != exp_n || st !== exp_st || rd !== exp_dat) begin
                tests_failed++;
                $display("FAIL random[%0d] we=%b mode=%0d dly=%0d: hung=%b held=%b end=%b cycles=%0d st=%b dat=%h, required cycles %0d st %b dat %h",
                         i, we, mode, dly, hung, held, eok, nc, st, rd, exp_n, exp_st, exp_dat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_min_latency();
        test_delayed_read();
        test_timeout();
        test_timeout_boundary();
        test_ack_err();
        test_backpressure();
        test_reset_mid_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
